// File: rtl/red_pitaya_rail_watchdog_pkg.sv
// Shared types and constants for the rail watchdog: FSM states, register
// offsets and register reset defaults.
package rail_wdg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MONITOR = 2'd1,
        ST_LOST    = 2'd2,
        ST_HOLDOFF = 2'd3
    } wdg_state_e;

    localparam logic [31:0] REG_CTRL    = 32'h0000_0000;
    localparam logic [31:0] REG_THRESH  = 32'h0000_0004;
    localparam logic [31:0] REG_HOLDOFF = 32'h0000_0008;
    localparam logic [31:0] REG_STATUS  = 32'h0000_000C;
    localparam logic [31:0] REG_EVENTS  = 32'h0000_0010;

    // 10 us and 1 ms at 125 MHz
    localparam int unsigned THRESH_RST  = 1250;
    localparam int unsigned HOLDOFF_RST = 125000;

endpackage

// File: rtl/red_pitaya_rail_watchdog_if.sv
// System bus request/response bundle of the rail watchdog.
interface red_pitaya_rail_watchdog_if;

    logic [31:0] sys_addr;
    logic [31:0] sys_wdata;
    logic        sys_wen;
    logic        sys_ren;
    logic [31:0] sys_rdata;
    logic        sys_err;
    logic        sys_ack;

    modport master (
        output sys_addr, sys_wdata, sys_wen, sys_ren,
        input  sys_rdata, sys_err, sys_ack
    );

    modport slave (
        input  sys_addr, sys_wdata, sys_wen, sys_ren,
        output sys_rdata, sys_err, sys_ack
    );

endinterface

// File: rtl/red_pitaya_rail_watchdog_regs.sv
// Bus decode, control/threshold registers and registered read/ack path.
module rail_wdg_regs
    import rail_wdg_pkg::*;
#(
    parameter int unsigned CNTW = 24,
    parameter int unsigned EVW  = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    red_pitaya_rail_watchdog_if.slave bus,
    input  wdg_state_e          state_i,
    input  logic [1:0]          rail_dir_i,
    input  logic                sticky_i,
    input  logic [EVW-1:0]      events_i,
    output logic                enable_o,
    output logic                clear_o,
    output logic [CNTW-1:0]     thresh_o,
    output logic [CNTW-1:0]     holdoff_o
);

    logic            enable_q;
    logic [CNTW-1:0] thresh_q;
    logic [CNTW-1:0] holdoff_q;
    logic [31:0]     rdata_q, rdata_d;
    logic            ack_q, ack_d;
    logic            unused_wdata;

    assign unused_wdata = ^bus.sys_wdata;

    // Clear is a strobe only; it is never stored, so CTRL bit1 reads 0.
    assign clear_o = bus.sys_wen && (bus.sys_addr == REG_CTRL) && bus.sys_wdata[1];

    // Register file writes, applied at the edge where sys_wen is high.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            enable_q  <= 1'b0;
            thresh_q  <= CNTW'(THRESH_RST);
            holdoff_q <= CNTW'(HOLDOFF_RST);
        end else if (bus.sys_wen) begin
            case (bus.sys_addr)
                REG_CTRL:    enable_q  <= bus.sys_wdata[0];
                REG_THRESH:  thresh_q  <= bus.sys_wdata[CNTW-1:0];
                REG_HOLDOFF: holdoff_q <= bus.sys_wdata[CNTW-1:0];
                default:     ;
            endcase
        end
    end

    // Read mux; unmapped offsets return zero.
    always_comb begin
        rdata_d = '0;
        ack_d   = bus.sys_wen | bus.sys_ren;
        if (bus.sys_ren) begin
            case (bus.sys_addr)
                REG_CTRL:    rdata_d[0]        = enable_q;
                REG_THRESH:  rdata_d[CNTW-1:0] = thresh_q;
                REG_HOLDOFF: rdata_d[CNTW-1:0] = holdoff_q;
                REG_STATUS:  rdata_d[4:0]      = {sticky_i, rail_dir_i, state_i};
                REG_EVENTS:  rdata_d[EVW-1:0]  = events_i;
                default:     ;
            endcase
        end
    end

    // One-cycle registered response.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q <= '0;
            ack_q   <= 1'b0;
        end else begin
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
        end
    end

    assign bus.sys_rdata = rdata_q;
    assign bus.sys_ack   = ack_q;
    assign bus.sys_err   = 1'b0;
    assign enable_o      = enable_q;
    assign thresh_o      = thresh_q;
    assign holdoff_o     = holdoff_q;

endmodule

// File: rtl/red_pitaya_rail_watchdog.sv
// Rail watchdog: debounces the limiter railed flag into lock-lost, pulses a
// relock request and blanks re-detection for a programmable holdoff.
module red_pitaya_rail_watchdog
    import rail_wdg_pkg::*;
#(
    parameter int unsigned CNTW = 24,
    parameter int unsigned EVW  = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] railed_i,
    output logic       lock_lost_o,
    output logic       relock_o,
    output logic [1:0] rail_dir_o,
    red_pitaya_rail_watchdog_if.slave sys
);

    wdg_state_e      state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            relock_q, relock_d;
    logic [1:0]      dir_q, dir_d;
    logic            sticky_q, sticky_d;
    logic [EVW-1:0]  events_q, events_d, events_base;

    logic            enable, clear;
    logic [CNTW-1:0] thresh, holdoff, thr_eff, hold_eff;
    logic [CNTW:0]   cnt_inc;
    logic            thr_hit, hold_hit, railed, lost_evt;

    rail_wdg_regs #(
        .CNTW (CNTW),
        .EVW  (EVW)
    ) u_regs (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .bus        (sys),
        .state_i    (state_q),
        .rail_dir_i (dir_q),
        .sticky_i   (sticky_q),
        .events_i   (events_q),
        .enable_o   (enable),
        .clear_o    (clear),
        .thresh_o   (thresh),
        .holdoff_o  (holdoff)
    );

    // A zero limit is treated as one sample.
    assign thr_eff  = (thresh  == '0) ? {{(CNTW-1){1'b0}}, 1'b1} : thresh;
    assign hold_eff = (holdoff == '0) ? {{(CNTW-1){1'b0}}, 1'b1} : holdoff;
    assign cnt_inc  = {1'b0, cnt_q} + {{CNTW{1'b0}}, 1'b1};
    assign thr_hit  = cnt_inc >= {1'b0, thr_eff};
    assign hold_hit = cnt_inc >= {1'b0, hold_eff};
    assign railed   = railed_i != 2'b00;

    // Next-state, counter, relock and event bookkeeping.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        relock_d = 1'b0;
        dir_d    = dir_q;
        lost_evt = 1'b0;
        if (!enable) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_MONITOR;
                    cnt_d   = '0;
                end
                ST_MONITOR: begin
                    if (!railed) begin
                        cnt_d = '0;
                    end else if (thr_hit) begin
                        state_d  = ST_LOST;
                        cnt_d    = '0;
                        relock_d = 1'b1;
                        dir_d    = railed_i;
                        lost_evt = 1'b1;
                    end else begin
                        cnt_d = cnt_inc[CNTW-1:0];
                    end
                end
                ST_LOST: begin
                    if (!railed) begin
                        state_d = ST_HOLDOFF;
                        cnt_d   = '0;
                    end
                end
                ST_HOLDOFF: begin
                    if (railed) begin
                        state_d = ST_LOST;
                        cnt_d   = '0;
                    end else if (hold_hit) begin
                        state_d = ST_MONITOR;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc[CNTW-1:0];
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        // A same-cycle clear is applied first so a coincident event still counts.
        events_base = clear ? '0 : events_q;
        events_d    = events_base;
        sticky_d    = clear ? 1'b0 : sticky_q;
        if (lost_evt) begin
            sticky_d = 1'b1;
            if (events_base != '1) begin
                events_d = events_base + {{(EVW-1){1'b0}}, 1'b1};
            end
        end
    end

    // State, counter and status registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            relock_q <= 1'b0;
            dir_q    <= 2'b00;
            sticky_q <= 1'b0;
            events_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            relock_q <= relock_d;
            dir_q    <= dir_d;
            sticky_q <= sticky_d;
            events_q <= events_d;
        end
    end

    assign lock_lost_o = (state_q == ST_LOST) || (state_q == ST_HOLDOFF);
    assign relock_o    = relock_q;
    assign rail_dir_o  = dir_q;

endmodule
